countdown_timer: RTL and testbench

Parametrised single-clock countdown engine replacing the fixed two-digit timer logic. It collects a DIGITS-wide BCD value from decoded keypad pulses and counts it down once per TICK_CYCLES clocks. It supports pause/resume, and exports BCD digits plus leading-zero blanking for the seven-segment scanner. It sits between the keypad decoder and the display driver. All timing comes from an internal prescaler, so no divided clocks are needed.

---
 rtl/countdown_timer.sv | 168 ++++++++++++++++
 tb/tb_countdown_timer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Keypad-loaded BCD countdown with an internal prescaler and leading-zero blanking.
// Define COUNTDOWN_PAUSE_EN to let the start key pause and resume a running countdown.
module countdown_timer #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned TICK_CYCLES = 100000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                keydown_num,
  input  logic [3:0]          num,
  input  logic                keydown_start,
  input  logic                keydown_confirm,
  input  logic                keydown_clear,
  output logic [4*DIGITS-1:0] digits,
  output logic [DIGITS-1:0]   blank,
  output logic                running,
  output logic                done
);

  localparam int unsigned DW = 4 * DIGITS;
  localparam int unsigned PW = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0]     LAST      = PW'(TICK_CYCLES - 1);
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_RUN,
`ifdef COUNTDOWN_PAUSE_EN
    S_PAUSE,
`endif
    S_DONE
  } state_t;

  state_t          state, state_n;
  logic [DW-1:0]   entry, entry_n;
  logic [DW-1:0]   remaining, remaining_n;
  logic [PW-1:0]   prescaler, prescaler_n;
  logic [DW-1:0]   disp_n;
  logic [DIGITS-1:0] blank_n;
  logic            tick;

  // BCD decrement by one; a zero digit borrows and becomes 9.
  function automatic logic [DW-1:0] bcd_dec(input logic [DW-1:0] v);
    logic       borrow;
    logic [3:0] d;
    bcd_dec = v;
    borrow  = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      d = v[4*i +: 4];
      if (borrow) begin
        if (d == 4'd0) begin
          bcd_dec[4*i +: 4] = 4'd9;
        end else begin
          bcd_dec[4*i +: 4] = d - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  endfunction

  // Digit i is dark when it and all higher digits are zero; units never blank.
  function automatic logic [DIGITS-1:0] blank_of(input logic [DW-1:0] v);
    logic nz;
    nz = 1'b0;
    blank_of = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      nz = nz | (v[4*i +: 4] != 4'd0);
      blank_of[i] = ~nz;
    end
    blank_of[0] = 1'b0;
  endfunction

  // Next-state and datapath; one event per cycle, clear first, tick before keys.
  always_comb begin
    state_n     = state;
    entry_n     = entry;
    remaining_n = remaining;
    prescaler_n = prescaler;
    tick        = (state == S_RUN) && (prescaler == LAST);

    if (keydown_clear) begin
      state_n     = S_IDLE;
      entry_n     = '0;
      remaining_n = '0;
      prescaler_n = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (keydown_confirm) begin
            remaining_n = entry;
            state_n     = S_ARMED;
          end else if (keydown_num && (num <= 4'd9)) begin
            entry_n = (entry << 4) | DW'(num);
          end
        end
        S_ARMED: begin
          if (keydown_start) begin
            if (remaining != '0) begin
              prescaler_n = '0;
              state_n     = S_RUN;
            end else begin
              state_n = S_DONE;
            end
          end else if (keydown_confirm) begin
            remaining_n = entry;
          end
        end
        S_RUN: begin
          if (tick) begin
            prescaler_n = '0;
            if (remaining == DW'(1)) begin
              remaining_n = '0;
              state_n     = S_DONE;
            end else begin
              remaining_n = bcd_dec(remaining);
            end
          end else begin
            prescaler_n = prescaler + PW'(1);
`ifdef COUNTDOWN_PAUSE_EN
            if (keydown_start) state_n = S_PAUSE;
`endif
          end
        end
`ifdef COUNTDOWN_PAUSE_EN
        S_PAUSE: begin
          if (keydown_start) state_n = S_RUN;
        end
`endif
        S_DONE: begin
          if (keydown_start && (entry != '0)) begin
            remaining_n = entry;
            prescaler_n = '0;
            state_n     = S_RUN;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end

    disp_n  = (state_n == S_IDLE) ? entry_n : remaining_n;
    blank_n = blank_of(disp_n);
  end

  // State, datapath and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      entry     <= '0;
      remaining <= '0;
      prescaler <= '0;
      digits    <= '0;
      blank     <= BLANK_RST;
      running   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      entry     <= entry_n;
      remaining <= remaining_n;
      prescaler <= prescaler_n;
      digits    <= disp_n;
      blank     <= blank_n;
      running   <= (state_n == S_RUN);
      done      <= (state_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: stimulus queues cycle-tagged expectations,
// a monitor compares them against the registered outputs on the tagged cycle.
module tb_countdown_timer;

  localparam int unsigned DIGITS      = 4;
  localparam int unsigned TICK_CYCLES = 4;

  typedef struct packed {
    int          at;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic        running;
    logic        done;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        keydown_num = 1'b0;
  logic [3:0]  num = 4'd0;
  logic        keydown_start = 1'b0;
  logic        keydown_confirm = 1'b0;
  logic        keydown_clear = 1'b0;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic        running;
  logic        done;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  exp_t  exp_q[$];
  string name_q[$];

  countdown_timer #(.DIGITS(DIGITS), .TICK_CYCLES(TICK_CYCLES)) dut (
    .clk(clk),
    .rst(rst),
    .keydown_num(keydown_num),
    .num(num),
    .keydown_start(keydown_start),
    .keydown_confirm(keydown_confirm),
    .keydown_clear(keydown_clear),
    .digits(digits),
    .blank(blank),
    .running(running),
    .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs d edges from now (the next edge is d=1).
  task automatic want(input int d, input string nm, input logic [15:0] dg,
                      input logic [3:0] bl, input logic r, input logic dn);
    exp_t e;
    e.at = cyc + d;
    e.digits = dg;
    e.blank = bl;
    e.running = r;
    e.done = dn;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic press(input logic n, input logic [3:0] v, input logic s,
                       input logic cf, input logic cl);
    keydown_num = n;
    num = v;
    keydown_start = s;
    keydown_confirm = cf;
    keydown_clear = cl;
    @(negedge clk);
    keydown_num = 1'b0;
    num = 4'd0;
    keydown_start = 1'b0;
    keydown_confirm = 1'b0;
    keydown_clear = 1'b0;
  endtask

  task automatic kn(input logic [3:0] v); press(1'b1, v, 1'b0, 1'b0, 1'b0); endtask
  task automatic ks(); press(1'b0, 4'd0, 1'b1, 1'b0, 1'b0); endtask
  task automatic kf(); press(1'b0, 4'd0, 1'b0, 1'b1, 1'b0); endtask
  task automatic kc(); press(1'b0, 4'd0, 1'b0, 1'b0, 1'b1); endtask

  // Monitor: after each edge, retire every expectation due at or before this cycle.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (e.at != cyc || digits !== e.digits || blank !== e.blank ||
            running !== e.running || done !== e.done) begin
          errors++;
          $display("FAIL %s: cycle %0d got digits=%h blank=%b running=%b done=%b, expected cycle %0d digits=%h blank=%b running=%b done=%b",
                   nm, cyc, digits, blank, running, done,
                   e.at, e.digits, e.blank, e.running, e.done);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    @(negedge clk);
    want(1, "reset", 16'h0000, 4'b1110, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Entry with wrap-around and out-of-range key
    want(1, "num1", 16'h0001, 4'b1110, 1'b0, 1'b0); kn(4'd1);
    want(1, "num2", 16'h0012, 4'b1100, 1'b0, 1'b0); kn(4'd2);
    want(1, "num3", 16'h0123, 4'b1000, 1'b0, 1'b0); kn(4'd3);
    want(1, "num4", 16'h1234, 4'b0000, 1'b0, 1'b0); kn(4'd4);
    want(1, "num5_wrap", 16'h2345, 4'b0000, 1'b0, 1'b0); kn(4'd5);
    want(1, "num10_ignored", 16'h2345, 4'b0000, 1'b0, 1'b0); kn(4'd10);
    want(1, "clear", 16'h0000, 4'b1110, 1'b0, 1'b0); kc();

    // Clear beats num; confirm/start with zero entry
    want(1, "num5", 16'h0005, 4'b1110, 1'b0, 1'b0); kn(4'd5);
    want(1, "clear_beats_num", 16'h0000, 4'b1110, 1'b0, 1'b0); press(1'b1, 4'd7, 1'b0, 1'b0, 1'b1);
    want(1, "confirm_zero", 16'h0000, 4'b1110, 1'b0, 1'b0); kf();
    want(1, "start_zero_done", 16'h0000, 4'b1110, 1'b0, 1'b1); ks();
    want(1, "clear_from_done", 16'h0000, 4'b1110, 1'b0, 1'b0); kc();

    // Countdown across borrow from 0100
    want(1, "e1", 16'h0001, 4'b1110, 1'b0, 1'b0); kn(4'd1);
    want(1, "e10", 16'h0010, 4'b1100, 1'b0, 1'b0); kn(4'd0);
    want(1, "e100", 16'h0100, 4'b1000, 1'b0, 1'b0); kn(4'd0);
    want(1, "confirm_100", 16'h0100, 4'b1000, 1'b0, 1'b0); kf();
    want(1, "armed_num_ignored", 16'h0100, 4'b1000, 1'b0, 1'b0); kn(4'd5);
    want(1, "start_100", 16'h0100, 4'b1000, 1'b1, 1'b0);
    want(4, "pre_tick", 16'h0100, 4'b1000, 1'b1, 1'b0);
    want(5, "tick_99", 16'h0099, 4'b1100, 1'b1, 1'b0);
    want(9, "tick_98", 16'h0098, 4'b1100, 1'b1, 1'b0);
    want(400, "pre_zero", 16'h0001, 4'b1110, 1'b1, 1'b0);
    want(401, "zero_done_400", 16'h0000, 4'b1110, 1'b0, 1'b1);
    ks();
    repeat (401) @(negedge clk);
    want(1, "done_restart", 16'h0100, 4'b1000, 1'b1, 1'b0); ks();
    want(1, "clear_in_run", 16'h0000, 4'b1110, 1'b0, 1'b0); kc();

    // Reset in the middle of a run
    want(1, "e4", 16'h0004, 4'b1110, 1'b0, 1'b0); kn(4'd4);
    want(1, "e42", 16'h0042, 4'b1100, 1'b0, 1'b0); kn(4'd2);
    want(1, "confirm_42", 16'h0042, 4'b1100, 1'b0, 1'b0); kf();
    want(1, "start_42", 16'h0042, 4'b1100, 1'b1, 1'b0); ks();
    @(negedge clk);
    want(1, "rst_mid_run", 16'h0000, 4'b1110, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    want(8, "no_tick_after_rst", 16'h0000, 4'b1110, 1'b0, 1'b0);
    repeat (8) @(negedge clk);

    // Start on the decrement-to-zero cycle lands in DONE
    want(1, "e1b", 16'h0001, 4'b1110, 1'b0, 1'b0); kn(4'd1);
    want(1, "confirm_1", 16'h0001, 4'b1110, 1'b0, 1'b0); kf();
    want(1, "start_1", 16'h0001, 4'b1110, 1'b1, 1'b0); ks();
    want(3, "pre_zero_1", 16'h0001, 4'b1110, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    want(1, "start_on_zero_done", 16'h0000, 4'b1110, 1'b0, 1'b1); ks();
    want(3, "stay_done", 16'h0000, 4'b1110, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    want(1, "clear2", 16'h0000, 4'b1110, 1'b0, 1'b0); kc();

    // Start pressed while running: pause/resume, or ignored without pause support
    want(1, "e3", 16'h0003, 4'b1110, 1'b0, 1'b0); kn(4'd3);
    want(1, "confirm_3", 16'h0003, 4'b1110, 1'b0, 1'b0); kf();
    want(1, "start_3", 16'h0003, 4'b1110, 1'b1, 1'b0); ks();
    want(4, "tick_2", 16'h0002, 4'b1110, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
`ifdef COUNTDOWN_PAUSE_EN
    want(1, "pause", 16'h0002, 4'b1110, 1'b0, 1'b0); ks();
    want(24, "paused_hold", 16'h0002, 4'b1110, 1'b0, 1'b0);
    repeat (49) @(negedge clk);
    want(1, "resume", 16'h0002, 4'b1110, 1'b1, 1'b0); ks();
    want(1, "post_resume", 16'h0002, 4'b1110, 1'b1, 1'b0);
    want(2, "first_tick_after_resume", 16'h0001, 4'b1110, 1'b1, 1'b0);
    want(5, "pre_done_62", 16'h0001, 4'b1110, 1'b1, 1'b0);
    want(6, "done_62", 16'h0000, 4'b1110, 1'b0, 1'b1);
    repeat (7) @(negedge clk);
`else
    want(1, "start_in_run_ignored", 16'h0002, 4'b1110, 1'b1, 1'b0); ks();
    want(2, "tick_1", 16'h0001, 4'b1110, 1'b1, 1'b0);
    want(5, "pre_done_12", 16'h0001, 4'b1110, 1'b1, 1'b0);
    want(6, "done_12", 16'h0000, 4'b1110, 1'b0, 1'b1);
    repeat (7) @(negedge clk);
`endif

    for (int i = 0; i < 1000 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors += exp_q.size();
      $display("FAIL drain: %0d expectations still pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
